// File: rtl/pix_stream_pkg.sv
// Shared types for the pixel stream sink and its capture FIFO.
package pix_stream_pkg;

  localparam int DATA_W_DEF = 8;

  // Sink controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Position tags carried with each output beat.
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } frame_flags_t;

endpackage

// File: rtl/pix_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Push and pop may coincide; at full, the pop frees the slot the push uses.
// At empty there is no bypass: pushed data shows at the head next cycle.
module pix_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        pop_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  // Storage array; no reset needed since the head is only observed when not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/pixel_stream_sink.sv
// Requests one frame of pixels from an upstream stage, captures them into a
// credit-protected FIFO and re-emits them as a tagged valid/ready stream.
// Output handshake: a beat transfers on a cycle where out_valid && out_ready;
// while out_valid && !out_ready, out_data and the flags hold steady, and
// out_valid never drops without a transfer.
module pixel_stream_sink
  import pix_stream_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 12,
  parameter int DATA_LAG   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  frame_w,
  input  logic [CNT_W-1:0]  frame_h,
  output logic              req,
  input  logic              ack,
  input  logic [DATA_W-1:0] pix_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output state_e            state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = 2 * CNT_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
  logic [CNT_W-1:0]  w_eff, h_eff;
  logic [TW-1:0]     total_q, total_d, issued_q, issued_d;
  logic [CW-1:0]     outst_q, outst_d, credit_q, credit_d;
  logic              req_q, req_d, ovf_q, ovf_d, last_q, last_d;
  logic              ack_live, ack_eff, ack_spur, cap_push, beat;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  frame_flags_t      flags;

  assign w_eff = (frame_w == '0) ? CNT_W'(1) : frame_w;
  assign h_eff = (frame_h == '0) ? CNT_W'(1) : frame_h;

  // Acks only matter while a frame is running; an ack with nothing
  // outstanding is flagged and never captured.
  assign ack_live = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign ack_eff  = ack && ack_live && (outst_q != '0);
  assign ack_spur = ack && ack_live && (outst_q == '0);

  // Delay accepted acks so the FIFO write lines up with valid pix_in.
  generate
    if (DATA_LAG == 0) begin : g_no_lag
      assign cap_push = ack_eff;
    end else begin : g_lag
      logic [DATA_LAG-1:0] lag_q;
      // Ack delay line, one stage per cycle of data lag.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) lag_q <= '0;
        else     lag_q <= (lag_q << 1) | DATA_LAG'(ack_eff);
      end
      assign cap_push = lag_q[DATA_LAG-1];
    end
  endgenerate

  pix_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (cap_push),
    .push_data_i (pix_in),
    .pop_i       (beat),
    .pop_data_o  (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign beat      = out_valid && out_ready;

  // Position tags derived from the column/row of the head beat.
  always_comb begin
    flags     = '0;
    flags.sof = out_valid && (col_q == '0) && (row_q == '0);
    flags.eol = out_valid && (col_q == w_q - CNT_W'(1));
    flags.eof = flags.eol && (row_q == h_q - CNT_W'(1));
  end

  // Next-state logic for the controller, counters and the request register.
  // Credit counts every pixel requested but not yet popped downstream
  // (outstanding, in the lag line, or sitting in the FIFO), so a request is
  // only made when a FIFO slot is guaranteed for its pixel.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    h_d      = h_q;
    total_d  = total_q;
    issued_d = issued_q + TW'(req_q);
    credit_d = credit_q + CW'(req_q) - CW'(beat);
    ovf_d    = ovf_q | ack_spur;
    last_d   = last_q;
    col_d    = col_q;
    row_d    = row_q;
    case ({req_q, ack_eff})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
    if (beat) begin
      if (flags.eol) begin
        col_d = '0;
        row_d = row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
      if (flags.eof) last_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          w_d      = w_eff;
          h_d      = h_eff;
          total_d  = TW'(w_eff) * TW'(h_eff);
          issued_d = '0;
          col_d    = '0;
          row_d    = '0;
          ovf_d    = 1'b0;
          last_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (issued_q == total_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_q && (outst_q == '0) && (fifo_count == '0)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_RUN) && (issued_d < total_d) &&
            (credit_d < CW'(FIFO_DEPTH));
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      w_q      <= '0;
      h_q      <= '0;
      total_q  <= '0;
      issued_q <= '0;
      outst_q  <= '0;
      credit_q <= '0;
      req_q    <= 1'b0;
      ovf_q    <= 1'b0;
      last_q   <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      h_q      <= h_d;
      total_q  <= total_d;
      issued_q <= issued_d;
      outst_q  <= outst_d;
      credit_q <= credit_d;
      req_q    <= req_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  assign req       = req_q;
  assign out_data  = out_valid ? fifo_head : '0;
  assign out_sof   = flags.sof;
  assign out_eol   = flags.eol;
  assign out_eof   = flags.eof;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Bench for pixel_stream_sink: upstream stage model, output-ready driver,
// beat monitor with expected-pixel queue and frame-position model.
module tb_pixel_stream_sink;
  import pix_stream_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] frame_w, frame_h;
  logic        req, ack, out_valid, out_ready;
  logic [7:0]  pix_in, out_data;
  logic        out_sof, out_eol, out_eof, busy, done, overflow;
  state_e      state_dbg;

  always #5 clk = ~clk;

  pixel_stream_sink dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_w   (frame_w),
    .frame_h   (frame_h),
    .req       (req),
    .ack       (ack),
    .pix_in    (pix_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         mw = 1, mh = 1;
  int         frame_beats = 0, frame_reqs = 0, done_cnt = 0;
  int         ack_lat = 5;
  int         pix_n = 0;
  bit         pix_fixed = 1'b1;
  bit         spur_req = 1'b0;
  int         ready_mode = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- upstream stage model ----------------
  // ack = req delayed ack_lat cycles; pixel valid one cycle after its ack.
  logic [63:0] req_hist;
  bit          ack_real;
  logic [7:0]  up_v;
  initial begin
    ack = 1'b0; pix_in = '0; req_hist = '0; ack_real = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        req_hist = '0; ack = 1'b0; ack_real = 1'b0; pix_in = '0;
      end else begin
        if (ack_real) begin
          up_v = pix_fixed ? 8'(10 + pix_n) : 8'($urandom);
          pix_n++;
          exp_q.push_back(up_v);
          pix_in = up_v;
        end else begin
          pix_in = 8'($urandom);
        end
        req_hist = {req_hist[62:0], req};
        ack_real = req_hist[ack_lat];
        ack = ack_real | spur_req;
        spur_req = 1'b0;
      end
    end
  end

  // ---------------- output ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        2:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  bit         hold_v = 1'b0;
  logic [7:0] hold_d;
  logic [2:0] hold_f;
  logic       prev_busy = 1'b0;
  logic [7:0] exp_pix;
  int         b, col, row;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0; prev_busy = 1'b0;
      end else begin
        if (req) frame_reqs++;
        if (done) begin
          done_cnt++;
          chk("busy_low_at_done", busy, 0);
          chk("busy_high_before_done", prev_busy, 1);
        end
        prev_busy = busy;
        if (hold_v) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, hold_d);
          chk("stall_flags", {out_sof, out_eol, out_eof}, hold_f);
        end
        if (out_valid && out_ready) begin
          b = frame_beats;
          col = b % mw;
          row = b / mw;
          if (exp_q.size() == 0) begin
            chk("exp_underflow", 1, 0);
          end else begin
            exp_pix = exp_q.pop_front();
            chk("beat_data", out_data, exp_pix);
          end
          chk("beat_sof", out_sof, (b == 0));
          chk("beat_eol", out_eol, (col == mw - 1));
          chk("beat_eof", out_eof, (b == mw * mh - 1));
          frame_beats++;
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_f = {out_sof, out_eol, out_eof};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input int w, input int h);
    mw = (w == 0) ? 1 : w;
    mh = (h == 0) ? 1 : h;
    frame_beats = 0; frame_reqs = 0; done_cnt = 0; pix_n = 0;
    frame_w = 12'(w); frame_h = 12'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_req", req, 1);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", (done_cnt == 0), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("beat_count", frame_beats, mw * mh);
    chk("exp_empty", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
    chk("state_idle", state_dbg, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1; start = 1'b0; frame_w = '0; frame_h = '0;
    #3;
    chk("rst_req", req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_flags", {out_sof, out_eol, out_eof}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_state", state_dbg, ST_IDLE);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 4x2 frame, ack latency 5, ready high, pixels 10+n
    ack_lat = 5; pix_fixed = 1'b1; ready_mode = 0;
    start_frame(4, 2);
    wait_done(300);
    chk("t1_overflow", overflow, 0);

    // ready held low: credits stop requests at FIFO depth
    ready_mode = 1;
    start_frame(8, 4);
    repeat (39) @(posedge clk);
    #1;
    chk("t2_reqs_at_depth", frame_reqs, 16);
    chk("t2_req_off", req, 0);
    chk("t2_valid", out_valid, 1);
    ready_mode = 0;
    wait_done(500);
    chk("t2_overflow", overflow, 0);

    // 16x16, ack latency 1, ready toggling, random pixels
    ack_lat = 1; pix_fixed = 1'b0; ready_mode = 2;
    start_frame(16, 16);
    wait_done(3000);

    // spurious ack while idle is ignored
    ready_mode = 0;
    spur_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_spur_ignored", overflow, 0);

    // spurious ack during RUN with nothing outstanding
    ack_lat = 5; ready_mode = 1;
    start_frame(8, 4);
    repeat (39) @(posedge clk);
    spur_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("run_spur_overflow", overflow, 1);
    ready_mode = 0;
    wait_done(500);
    chk("overflow_sticky", overflow, 1);
    start_frame(2, 1);
    chk("overflow_cleared", overflow, 0);
    wait_done(200);

    // start during RUN is ignored
    ack_lat = 3;
    start_frame(4, 2);
    repeat (2) @(posedge clk);
    #1;
    frame_w = 12'd2; frame_h = 12'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(300);

    // reset mid-frame after 5 beats, then a 0x0 frame
    start_frame(4, 4);
    n = 0;
    while (frame_beats < 5 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_wait_timeout", (frame_beats < 5), 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_state", state_dbg, ST_IDLE);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    start_frame(0, 0);
    wait_done(100);
    chk("one_px_overflow", overflow, 0);

    // random frames with random ready and latency
    pix_fixed = 1'b0; ready_mode = 3;
    for (int r = 0; r < 3; r++) begin
      ack_lat = $urandom_range(1, 8);
      start_frame($urandom_range(1, 6), $urandom_range(1, 4));
      wait_done(1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
